// File: rtl/dso100_video_pkg.sv
// rtl/dso100_video_pkg.sv - shared Bayer matrix, colour bars and dither offset helper
package dso100_video_pkg;

  // 4x4 ordered-dither thresholds, indexed [row = y[1:0]][column = x[1:0]]
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] COLOR_BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Scale a 4-bit threshold to the weight of the d dropped bits.
  // The result always stays below 2^d, so it never carries past one output LSB.
  function automatic logic [7:0] dither_offset(input logic [3:0] t, input int d);
    logic [7:0] tw;
    tw = {4'b0000, t};
    if (d <= 0)
      return 8'd0;
    else if (d >= 4)
      return tw << (d - 4);
    else
      return tw >> (4 - d);
  endfunction

endpackage

// File: rtl/dso100_channel_dither.sv
// rtl/dso100_channel_dither.sv - one colour channel: add dither offset, clamp, truncate to N bits
module dso100_channel_dither
  import dso100_video_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [7:0]   chan,
  input  logic [3:0]   t,
  input  logic         en,
  output logic [N-1:0] q
);

  localparam int D = 8 - N;

  logic [7:0] offset;
  logic [8:0] sum;
  logic [7:0] sat;

  // Offset add at 9 bits so a carry can be clamped instead of wrapping to black
  always_comb begin
    offset = en ? dither_offset(t, D) : 8'd0;
    sum    = {1'b0, chan} + {1'b0, offset};
    sat    = sum[8] ? 8'hFF : sum[7:0];
  end

  // Stage-2 output register keeps the N most significant bits
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      q <= '0;
    else
      q <= sat[7:D];
  end

endmodule

// File: rtl/dso100_video_formatter_dither.sv
// rtl/dso100_video_formatter_dither.sv - RGB888 to packed panel bus with Bayer dither; DSO100_VF_TEST_PATTERN_EN adds colour bars
module dso100_video_formatter_dither
  import dso100_video_pkg::*;
#(
  parameter int R_BITS = 5,
  parameter int G_BITS = 6,
  parameter int B_BITS = 5,
  parameter bit HS_INV = 1'b0,
  parameter bit VS_INV = 1'b0,
  parameter int CNT_W  = 12
`ifdef DSO100_VF_TEST_PATTERN_EN
  ,
  parameter int BAR_W  = 160
`endif
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [31:0]                      VID_DATA,
  input  logic                             VID_DE,
  input  logic                             VID_HSYNC,
  input  logic                             VID_VSYNC,
  input  logic                             DITHER_EN,
`ifdef DSO100_VF_TEST_PATTERN_EN
  input  logic                             TP_SEL,
`endif
  output logic [R_BITS+G_BITS+B_BITS-1:0]  OUT_D,
  output logic                             OUT_DE,
  output logic                             OUT_HS,
  output logic                             OUT_VS
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] x, y;
  logic             de_prev, vs_prev, dither_q;
  logic             de_fall, vs_rise;
  logic [23:0]      src;
  logic [23:0]      d1;
  logic [3:0]       t1;
  logic             en1, de1, hs1, vs1;
  logic [R_BITS-1:0] r_q;
  logic [G_BITS-1:0] g_q;
  logic [B_BITS-1:0] b_q;
  logic             unused_hi;

  assign unused_hi = ^VID_DATA[31:24];
  assign de_fall   = de_prev & ~VID_DE;
  assign vs_rise   = ~vs_prev & VID_VSYNC;

  // Pixel/line position and the per-frame dither latch; VSYNC clear beats the line increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x        <= '0;
      y        <= '0;
      de_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      dither_q <= 1'b0;
    end else begin
      de_prev <= VID_DE;
      vs_prev <= VID_VSYNC;
      if (VID_DE) begin
        if (x != CNT_MAX) x <= x + 1'b1;
      end else if (de_fall) begin
        x <= '0;
      end
      if (vs_rise)
        y <= '0;
      else if (de_fall && y != CNT_MAX)
        y <= y + 1'b1;
      if (vs_rise) dither_q <= DITHER_EN;
    end
  end

`ifdef DSO100_VF_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

  logic             tp_q;
  logic [CNT_W-1:0] bar_q;

  // Test-pattern select is frame-latched together with the dither request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      tp_q <= 1'b0;
    else if (vs_rise)
      tp_q <= TP_SEL;
  end

  // Bar index is the column divided by bar width, wrapping every eight bars
  always_comb begin
    bar_q = x / BAR_W_C;
    src   = tp_q ? COLOR_BARS[bar_q[2:0]] : VID_DATA[23:0];
  end
`else
  assign src = VID_DATA[23:0];
`endif

  // Stage 1: capture pixel (zeroed in blanking), threshold and dither enable
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d1  <= '0;
      t1  <= '0;
      en1 <= 1'b0;
      de1 <= 1'b0;
      hs1 <= HS_INV;
      vs1 <= VS_INV;
    end else begin
      d1  <= VID_DE ? src : 24'd0;
      t1  <= BAYER[y[1:0]][x[1:0]];
      en1 <= dither_q & VID_DE;
      de1 <= VID_DE;
      hs1 <= VID_HSYNC ^ HS_INV;
      vs1 <= VID_VSYNC ^ VS_INV;
    end
  end

  dso100_channel_dither #(.N(R_BITS)) u_red (
    .CLK(CLK), .RST_N(RST_N), .chan(d1[23:16]), .t(t1), .en(en1), .q(r_q)
  );
  dso100_channel_dither #(.N(G_BITS)) u_green (
    .CLK(CLK), .RST_N(RST_N), .chan(d1[15:8]), .t(t1), .en(en1), .q(g_q)
  );
  dso100_channel_dither #(.N(B_BITS)) u_blue (
    .CLK(CLK), .RST_N(RST_N), .chan(d1[7:0]), .t(t1), .en(en1), .q(b_q)
  );

  // Stage 2: control signals registered alongside the channel results
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_DE <= 1'b0;
      OUT_HS <= HS_INV;
      OUT_VS <= VS_INV;
    end else begin
      OUT_DE <= de1;
      OUT_HS <= hs1;
      OUT_VS <= vs1;
    end
  end

  assign OUT_D = {r_q, g_q, b_q};

endmodule

// File: tb/tb_dso100_video_formatter_dither.sv
// tb/tb_dso100_video_formatter_dither.sv - directed checks of truncation, dither, latching, syncs and reset
module tb_dso100_video_formatter_dither;

  localparam bit HS_INV_P = 1'b1;
  localparam bit VS_INV_P = 1'b0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] VID_DATA = '0;
  logic        VID_DE = 1'b0, VID_HSYNC = 1'b0, VID_VSYNC = 1'b0, DITHER_EN = 1'b0;
`ifdef DSO100_VF_TEST_PATTERN_EN
  logic        TP_SEL = 1'b0;
`endif
  logic [15:0] OUT_D;
  logic        OUT_DE, OUT_HS, OUT_VS;

  int n_checks = 0;
  int n_errors = 0;

  logic        p_valid = 1'b0;
  logic        p_chk, p_de, p_hs, p_vs;
  logic [15:0] p_exp;
  string       p_tag;

  always #5 CLK = ~CLK;

  dso100_video_formatter_dither #(
    .R_BITS(5), .G_BITS(6), .B_BITS(5),
    .HS_INV(HS_INV_P), .VS_INV(VS_INV_P), .CNT_W(12)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .VID_DATA(VID_DATA), .VID_DE(VID_DE), .VID_HSYNC(VID_HSYNC), .VID_VSYNC(VID_VSYNC),
    .DITHER_EN(DITHER_EN),
`ifdef DSO100_VF_TEST_PATTERN_EN
    .TP_SEL(TP_SEL),
`endif
    .OUT_D(OUT_D), .OUT_DE(OUT_DE), .OUT_HS(OUT_HS), .OUT_VS(OUT_VS)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One input cycle; outputs of the previous call's inputs are due now (2-cycle latency)
  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] data,
                     input logic chk, input logic [15:0] exp, input string tag);
    VID_DE = de; VID_HSYNC = hs; VID_VSYNC = vs; VID_DATA = {8'hA5, data};
    @(posedge CLK); #1;
    if (p_valid && p_chk) begin
      check({p_tag, "_d"},  OUT_D,  p_exp);
      check({p_tag, "_de"}, OUT_DE, p_de);
      check({p_tag, "_hs"}, OUT_HS, p_hs ^ HS_INV_P);
      check({p_tag, "_vs"}, OUT_VS, p_vs ^ VS_INV_P);
    end
    p_valid = 1'b1; p_chk = chk; p_exp = exp; p_de = de; p_hs = hs; p_vs = vs; p_tag = tag;
  endtask

  task automatic px(input logic [23:0] data, input logic [15:0] exp, input string tag);
    cyc(1'b1, 1'b0, 1'b0, data, 1'b1, exp, tag);
  endtask

  task automatic blank(input int n, input string tag);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 24'h777777, 1'b1, 16'h0000, tag);
  endtask

  task automatic hsync_pulse();
    cyc(1'b0, 1'b1, 1'b0, 24'h777777, 1'b1, 16'h0000, "hs");
    cyc(1'b0, 1'b0, 1'b0, 24'h777777, 1'b1, 16'h0000, "hs_end");
  endtask

  task automatic vsync_pulse(input logic dith);
    DITHER_EN = dith;
    cyc(1'b0, 1'b0, 1'b1, 24'h777777, 1'b1, 16'h0000, "vs");
    cyc(1'b0, 1'b0, 1'b0, 24'h777777, 1'b1, 16'h0000, "vs_end");
  endtask

  task automatic zero_line(input string tag);
    px(24'h000000, 16'h0000, tag);
    blank(1, "eol");
    hsync_pulse();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached 1 expected 0");
    $fatal(1);
  end

  initial begin
    // Reset held with active input
    VID_DE = 1'b1; VID_HSYNC = 1'b1; VID_VSYNC = 1'b1; VID_DATA = 32'h00FFFFFF; DITHER_EN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_d", OUT_D, 16'h0000);
    check("rst_de", OUT_DE, 1'b0);
    check("rst_hs", OUT_HS, HS_INV_P);
    check("rst_vs", OUT_VS, VS_INV_P);

    // First pixel after release: {0x12>>3, 0x34>>2, 0x56>>3}
    DITHER_EN = 1'b0;
    RST_N = 1'b1;
    px(24'h123456, 16'h11AA, "first");
    blank(2, "eol");
    hsync_pulse();

    // Frame without dither: plain truncation
    vsync_pulse(1'b0);
    px(24'h840000, 16'h8000, "trunc_x0");
    px(24'h840000, 16'h8000, "trunc_x1");
    blank(2, "eol");
    hsync_pulse();

    // Dithered frame
    vsync_pulse(1'b1);
    px(24'h840000, 16'h8000, "dith_x0y0");
    px(24'h848484, 16'h8C31, "dith_x1y0");
    blank(2, "eol");
    hsync_pulse();
    zero_line("y1");
    zero_line("y2");
    px(24'h84FFFF, 16'h8FFF, "dith_x0y3");
    px(24'hFFFFFF, 16'hFFFF, "sat_x1y3");
    blank(2, "eol");
    hsync_pulse();
    zero_line("y4");
    zero_line("y5");
    zero_line("y6");
    px(24'hFFFFFF, 16'hFFFF, "sat_x0y7");
    blank(2, "eol");
    hsync_pulse();

    // Mid-frame dither request must wait for the next VSYNC rise
    vsync_pulse(1'b0);
    px(24'h840000, 16'h8000, "latch_x0");
    DITHER_EN = 1'b1;
    px(24'h840000, 16'h8000, "latch_x1");
    px(24'h840000, 16'h8000, "latch_x2");
    // VSYNC rise in the same cycle as the DE fall
    cyc(1'b0, 1'b0, 1'b1, 24'h777777, 1'b1, 16'h0000, "vs_defall");
    cyc(1'b0, 1'b0, 1'b0, 24'h777777, 1'b1, 16'h0000, "vs_end");
    hsync_pulse();
    px(24'h840000, 16'h8000, "post_x0y0");
    px(24'h840000, 16'h8800, "post_x1y0");
    blank(2, "eol");
    hsync_pulse();

    // Line y=1 dithered, then reset in the middle of it
    px(24'h840000, 16'h8800, "pre_rst_x0y1");
    px(24'h000000, 16'h0000, "pre_rst_x1y1");
    RST_N = 1'b0;
    #1;
    check("rst_mid_d", OUT_D, 16'h0000);
    check("rst_mid_de", OUT_DE, 1'b0);
    check("rst_mid_hs", OUT_HS, HS_INV_P);
    check("rst_mid_vs", OUT_VS, VS_INV_P);
    p_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    px(24'h848484, 16'h8430, "resume_x0");
    px(24'h840000, 16'h8000, "resume_x1");
    blank(2, "eol");
    hsync_pulse();

`ifdef DSO100_VF_TEST_PATTERN_EN
    // Colour bars, dither off
    TP_SEL = 1'b1;
    vsync_pulse(1'b0);
    for (int i = 0; i < 1280; i++) begin
      logic [15:0] e;
      e = (i == 0) ? 16'hFFFF : (i == 160) ? 16'hFFE0 : 16'h0000;
      cyc(1'b1, 1'b0, 1'b0, 24'h123456, (i == 0 || i == 160 || i == 1279), e, "tp_bar");
    end
    blank(2, "eol");
    TP_SEL = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
